// File: rtl/booth_mult_ctrl_pkg.sv
// Shared types for the radix-2 Booth multiplier: controller state encoding and
// the add/sub/nop decision taken from the {Q[0], q-1} bit pair.
package booth_mult_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_t;

    // 10 starts a run of ones (subtract M), 01 ends one (add M).
    function automatic booth_op_t booth_decode(input logic q0, input logic q_m1);
        case ({q0, q_m1})
            2'b10:   return OP_SUB;
            2'b01:   return OP_ADD;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_mult_ctrl_step.sv
// One combinational radix-2 Booth step: conditional add/sub of M into A, then an
// arithmetic right shift of the concatenation {A, Q, q-1}.
module booth_mult_ctrl_step
    import booth_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_m1_next
);

    logic [WIDTH:0] sum;

    always_comb begin
        // NOTE: every output of this block gets a value on every path, so no latch is inferred.
        sum = a;
        case (booth_decode(q[0], q_m1))
            OP_ADD:  sum = a + m;
            OP_SUB:  sum = a - m;
            default: sum = a;
        endcase
        a_next    = {sum[WIDTH], sum[WIDTH:1]};
        q_next    = {sum[0], q[WIDTH-1:1]};
        q_m1_next = q[0];
    end

endmodule

// File: rtl/booth_mult_ctrl.sv
// Sequential radix-2 Booth multiplier controller: start/done handshake, WIDTH
// Booth steps per operation, signed 2*WIDTH-bit product held until the next completion.
module booth_mult_ctrl
    import booth_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_multiplicand,
    input  logic [WIDTH-1:0]   i_multiplier,
    output logic               o_busy,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    state_t state, state_next;

    // A carries one guard bit so that subtracting M = -2^(WIDTH-1) cannot overflow.
    logic [WIDTH:0]   acc, acc_next, m_ext;
    logic [WIDTH-1:0] q_reg, q_next;
    logic             q_m1, q_m1_next;
    logic [CW-1:0]    count;
    logic             accept;
    logic             last_step;

    assign accept    = i_start && (state == ST_IDLE || state == ST_DONE);
    assign last_step = (state == ST_RUN) && (count == LAST_COUNT);

    booth_mult_ctrl_step #(.WIDTH(WIDTH)) u_step (
        .a         (acc),
        .q         (q_reg),
        .q_m1      (q_m1),
        .m         (m_ext),
        .a_next    (acc_next),
        .q_next    (q_next),
        .q_m1_next (q_m1_next)
    );

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: state_next = i_start ? ST_RUN : ST_IDLE;
            ST_RUN:  state_next = last_step ? ST_DONE : ST_RUN;
            ST_DONE: state_next = i_start ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state == ST_RUN);
        o_done = (state == ST_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc       <= '0;
            q_reg     <= '0;
            q_m1      <= 1'b0;
            m_ext     <= '0;
            count     <= '0;
            o_product <= '0;
        end else if (accept) begin
            acc   <= '0;
            q_reg <= i_multiplier;
            q_m1  <= 1'b0;
            m_ext <= {i_multiplicand[WIDTH-1], i_multiplicand};
            count <= '0;
        end else if (state == ST_RUN) begin
            acc   <= acc_next;
            q_reg <= q_next;
            q_m1  <= q_m1_next;
            count <= count + CW'(1);
            // The guard bit of A is pure sign and drops out of the product.
            if (last_step) begin
                o_product <= {acc_next[WIDTH-1:0], q_next};
            end
        end
    end

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Self-checking bench: a WIDTH=4 instance (exhaustive) and a WIDTH=32 instance
// (directed corners plus random pairs), both compared every cycle to a signed-multiply model.
module tb_booth_mult_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       s4;
    logic [3:0] m4, q4;
    logic       busy4, done4;
    logic [7:0] p4;

    logic        s32;
    logic [31:0] m32, q32;
    logic        busy32, done32;
    logic [63:0] p32;

    int n_tests = 0;
    int n_fail  = 0;

    booth_mult_ctrl #(.WIDTH(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_start(s4),
        .i_multiplicand(m4), .i_multiplier(q4),
        .o_busy(busy4), .o_done(done4), .o_product(p4)
    );

    booth_mult_ctrl #(.WIDTH(32)) dut32 (
        .i_clk(clk), .i_rst(rst), .i_start(s32),
        .i_multiplicand(m32), .i_multiplier(q32),
        .o_busy(busy32), .o_done(done32), .o_product(p32)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an accepted start schedules the signed product to appear
    // WIDTH edges later; starts while an operation is pending are ignored.
    bit          mb4, md4, mb32, md32;
    int          mc4, mc32;
    logic [7:0]  mp4, pend4;
    logic [63:0] mp32, pend32;

    always @(posedge clk) begin
        if (rst) begin
            mb4 = 0; md4 = 0; mc4 = 0; mp4 = '0;
            mb32 = 0; md32 = 0; mc32 = 0; mp32 = '0;
        end else begin
            if (mb4) begin
                mc4--;
                if (mc4 == 0) begin mb4 = 0; md4 = 1; mp4 = pend4; end
            end else begin
                md4 = 0;
                if (s4) begin
                    mb4 = 1; mc4 = 4;
                    pend4 = 8'(longint'($signed(m4)) * longint'($signed(q4)));
                end
            end
            if (mb32) begin
                mc32--;
                if (mc32 == 0) begin mb32 = 0; md32 = 1; mp32 = pend32; end
            end else begin
                md32 = 0;
                if (s32) begin
                    mb32 = 1; mc32 = 32;
                    pend32 = 64'(longint'($signed(m32)) * longint'($signed(q32)));
                end
            end
        end
    end

    always @(negedge clk) begin
        check("busy4", 64'(busy4), 64'(mb4));
        check("done4", 64'(done4), 64'(md4));
        check("prod4", 64'(p4), 64'(mp4));
        check("busy32", 64'(busy32), 64'(mb32));
        check("done32", 64'(done32), 64'(md32));
        check("prod32", p32, mp32);
    end

    // Starts one 32-bit op (called right after a negedge) and checks latency,
    // busy duration and the hand-computed product.
    task automatic run32(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
        int k = 0, nb = 0;
        s32 = 1'b1; m32 = a; q32 = b;
        forever begin
            @(negedge clk);
            k++;
            if (k == 1) s32 = 1'b0;
            if (busy32) nb++;
            if (done32 || k > 45) break;
        end
        check({name, "_lat"}, 64'(k), 64'd33);
        check({name, "_busy"}, 64'(nb), 64'd32);
        check({name, "_prod"}, p32, exp);
    endtask

    initial begin
        int k, nd;
        rst = 1'b1; s4 = 0; m4 = '0; q4 = '0; s32 = 0; m32 = '0; q32 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy32), 64'd0);
        check("rst_done", 64'(done32), 64'd0);
        check("rst_prod", p32, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run32("basic", 32'd3, -32'sd5, 64'hFFFFFFFF_FFFFFFF1);
        run32("minsq", 32'h80000000, 32'h80000000, 64'h40000000_00000000);
        run32("min_x1", 32'h80000000, 32'd1, 64'hFFFFFFFF_80000000);
        run32("maxsq", 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001);
        run32("zero", 32'd0, 32'hFFFFFFFF, 64'd0);

        // Start pulse mid-run with different operands must be ignored.
        s32 = 1; m32 = 32'd7; q32 = 32'd6;
        k = 0; nd = 0;
        repeat (75) begin
            @(negedge clk);
            k++;
            s32 = (k == 10);
            if (k == 10) begin m32 = 32'd2; q32 = 32'd2; end
            if (k == 11) begin m32 = 32'd0; q32 = 32'd0; end
            if (done32) begin
                nd++;
                check("ign_prod", p32, 64'd42);
            end
        end
        check("ign_ndone", 64'(nd), 64'd1);

        // Back-to-back: start held across DONE launches the next op without IDLE.
        s32 = 1; m32 = 32'd6; q32 = 32'd7;
        k = 0;
        forever begin
            @(negedge clk);
            k++;
            if (k == 1) begin m32 = -32'sd4; q32 = -32'sd4; end
            if (done32 || k > 45) break;
        end
        check("b2b_lat1", 64'(k), 64'd33);
        check("b2b_prod1", p32, 64'd42);
        k = 0;
        forever begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                s32 = 0;
                check("b2b_no_idle", 64'(busy32), 64'd1);
            end
            if (done32 || k > 45) break;
        end
        check("b2b_lat2", 64'(k), 64'd33);
        check("b2b_prod2", p32, 64'd16);

        // Reset mid-run discards the operation and clears the product.
        @(negedge clk);
        s32 = 1; m32 = 32'd9; q32 = 32'd9;
        @(negedge clk);
        s32 = 0;
        repeat (14) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("mrst_busy", 64'(busy32), 64'd0);
        check("mrst_done", 64'(done32), 64'd0);
        check("mrst_prod", p32, 64'd0);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32) nd++;
        end
        check("mrst_nodone", 64'(nd), 64'd0);

        // WIDTH=4 exhaustive.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                s4 = 1; m4 = 4'(a); q4 = 4'(b);
                k = 0;
                forever begin
                    @(negedge clk);
                    k++;
                    if (k == 1) s4 = 0;
                    if (done4 || k > 10) break;
                end
                check("w4_lat", 64'(k), 64'd5);
            end
        end
        check("w4_last", 64'(p4), 64'h01);
        s4 = 1; m4 = 4'h8; q4 = 4'h8;
        @(negedge clk);
        s4 = 0;
        repeat (5) @(negedge clk);
        check("w4_minsq", 64'(p4), 64'h40);

        // WIDTH=32 random pairs, with random idle gaps so the product must hold.
        for (int i = 0; i < 1500; i++) begin
            s32 = 1; m32 = $urandom; q32 = $urandom;
            if (i % 8 == 0) m32 = 32'h80000000;
            k = 0;
            forever begin
                @(negedge clk);
                k++;
                if (k == 1) s32 = 0;
                if (done32 || k > 45) break;
            end
            check("rnd_lat", 64'(k), 64'd33);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
